reg_bank_arb: RTL and testbench
===============================

REG_BANK_ARB -- requirements
Module: reg_bank_arb

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 has an instruction pending.
REQ-005 inst0  input  12  requester 0 instruction: [11:8] opcode, [7:0] immediate.
REQ-006 grant0  output  1  one-cycle pulse: requester 0's instruction was forwarded.
REQ-007 req1  input  1  requester 1 has an instruction pending.
REQ-008 inst1  input  12  requester 1 instruction, same encoding as inst0.
REQ-009 grant1  output  1  one-cycle pulse: requester 1's instruction was forwarded.
REQ-010 inst  output  12  instruction to the register bank.
REQ-011 inst_en  output  1  inst is valid this cycle.
REQ-012 error  output  1  high while the arbiter is in the Error state.
REQ-013 count  output  8  number of instructions forwarded, modulo 256.

Function
REQ-014 States: Reset=2'h0, Ready=2'h1, Error=2'h2; encoding 2'h3 shall behave as Error.
REQ-015 Reset state: all outputs 0; next state Ready unconditionally.
REQ-016 Ready state: each cycle, at most one requester is selected; eligible = reqN high AND grantN low in the current cycle.
REQ-017 Ineligible requesters: a requester whose grant is high this cycle shall be ignored, so no instruction is issued twice.
REQ-018 Arbitration: only one eligible requester -> it wins; both eligible -> round-robin, the requester not served last wins.
REQ-019 Last-served pointer: after reset it indicates requester 1, so requester 0 wins the first tie; it updates only on a grant.
REQ-020 On a win (registered, visible next cycle): inst <= winner's instN, inst_en <= 1, grantN <= 1 for the winner only, count <= count+1.
REQ-021 Latency: request sampled at edge k -> inst/inst_en/grant valid in the cycle after edge k (1 cycle).
REQ-022 No win: inst_en <= 0, grant0 <= 0, grant1 <= 0; inst holds its last value; count holds.
REQ-023 Handshake: requester holds reqN and instN stable until it sees grantN; it may keep reqN high to queue its next instruction.
REQ-024 Throughput: one requester alone gets at most one grant every 2 cycles; both continuously requesting alternate grants every cycle.
REQ-025 Count wrap: count wraps 8'hFF -> 8'h00 with no flag.
REQ-026 Error state: all outputs except error forced to 0; error=1; sticky until reset.
REQ-027 Never: grant0 and grant1 high in the same cycle; inst_en high without exactly one grant high.

Reset
REQ-028 reset high at a clock edge, in any state (including mid-stream and Error): state <= Reset, pointer <= requester 1, grant0/grant1/inst_en/error <= 0, inst <= 12'h000, count <= 8'h00.
REQ-029 Instruction sampled in the reset cycle: discarded; no grant is issued for it.
REQ-030 First grant after reset: possible at the earliest 2 cycles after reset deasserts (Reset state, then Ready).

Configuration
REQ-031 Macro REG_BANK_ARB_OPCHECK_EN: when defined, a winning instruction with opcode > 4'h5 is not forwarded.
REQ-032 OPCHECK_EN defined, illegal opcode: no grant; inst_en <= 0; state <= Error.
REQ-033 OPCHECK_EN undefined: all opcodes are forwarded unchanged and the arbiter never enters Error from Ready.

Verification
REQ-034 Solo request: reset, then req0=1 with inst0=12'h2A5 held -> grant0, inst=12'h2A5, inst_en=1 one cycle later; grant0 repeats every 2nd cycle while req0 stays high; count increments per grant.
REQ-035 Contention: req0=req1=1, inst0=12'h311, inst1=12'h422 held from the first Ready cycle -> grants alternate 0,1,0,1 on consecutive cycles; inst alternates 12'h311/12'h422.
REQ-036 Count wrap: 256 solo grants -> count returns to 8'h00; grant 257 -> count=8'h01.
REQ-037 Opcheck (macro on): inst1=12'h9FF sole request -> no grant1, inst_en=0, error=1 next cycle and stays 1; then reset -> error=0, count=0.
REQ-038 Opcheck (macro off): inst1=12'h9FF -> forwarded with grant1=1, error stays 0.
REQ-039 Reset mid-stream: reset asserted while both requesters are active -> all outputs 0 next cycle; after release, requester 0 wins the first tie.

Source files
------------

// File: rtl/reg_bank_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arb
// Purpose  : Two-requester round-robin arbiter that forwards 12-bit
//            instructions to a register bank with registered grants.
//            Optional opcode legality check: REG_BANK_ARB_OPCHECK_EN.
// Revision : 1.0
// ============================================================================
module reg_bank_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [11:0] inst0,
  output logic        grant0,
  input  logic        req1,
  input  logic [11:0] inst1,
  output logic        grant1,
  output logic [11:0] inst,
  output logic        inst_en,
  output logic        error,
  output logic [7:0]  count
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'h0,
    ST_READY   = 2'h1,
    ST_ERROR   = 2'h2,
    ST_ERROR_X = 2'h3
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_grant0;
  logic        r_grant1;
  logic        r_inst_en;
  logic        r_error;
  logic [11:0] r_inst;
  logic [7:0]  r_count;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_win;
  logic        w_pick1;
  logic [11:0] w_win_inst;
  logic        w_illegal;

  // A requester granted last cycle is still presenting the instruction just sent.
  assign w_elig0    = req0 & ~r_grant0;
  assign w_elig1    = req1 & ~r_grant1;
  assign w_win      = w_elig0 | w_elig1;
  assign w_pick1    = w_elig1 & (~w_elig0 | ~r_last);
  assign w_win_inst = w_pick1 ? inst1 : inst0;

`ifdef REG_BANK_ARB_OPCHECK_EN
  assign w_illegal = (w_win_inst[11:8] > 4'h5);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RESET;
      r_last    <= 1'b1;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_inst_en <= 1'b0;
      r_error   <= 1'b0;
      r_inst    <= 12'h000;
      r_count   <= 8'h00;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state   <= ST_READY;
          r_grant0  <= 1'b0;
          r_grant1  <= 1'b0;
          r_inst_en <= 1'b0;
          r_error   <= 1'b0;
          r_inst    <= 12'h000;
          r_count   <= 8'h00;
        end
        ST_READY: begin
          if (w_win && w_illegal) begin
            r_state   <= ST_ERROR;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_inst_en <= 1'b0;
            r_error   <= 1'b1;
            r_inst    <= 12'h000;
            r_count   <= 8'h00;
          end else if (w_win) begin
            r_inst    <= w_win_inst;
            r_inst_en <= 1'b1;
            r_grant0  <= ~w_pick1;
            r_grant1  <= w_pick1;
            r_count   <= r_count + 8'h01;
            r_last    <= w_pick1;
          end else begin
            r_inst_en <= 1'b0;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
          end
        end
        default: begin
          // Error (and the unused encoding) is sticky until reset.
          r_state   <= ST_ERROR;
          r_grant0  <= 1'b0;
          r_grant1  <= 1'b0;
          r_inst_en <= 1'b0;
          r_error   <= 1'b1;
          r_inst    <= 12'h000;
          r_count   <= 8'h00;
        end
      endcase
    end
  end

  assign grant0  = r_grant0;
  assign grant1  = r_grant1;
  assign inst    = r_inst;
  assign inst_en = r_inst_en;
  assign error   = r_error;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_arb
// Purpose  : Self-checking bench for reg_bank_arb; reference model plus
//            directed vectors. Honours REG_BANK_ARB_OPCHECK_EN.
// Revision : 1.0
// ============================================================================
module tb_reg_bank_arb;

`ifdef REG_BANK_ARB_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0  = 1'b0;
  logic        req1  = 1'b0;
  logic [11:0] inst0 = 12'h000;
  logic [11:0] inst1 = 12'h000;
  logic        grant0, grant1, inst_en, error;
  logic [11:0] inst;
  logic [7:0]  count;

  int passed = 0;
  int total  = 0;

  reg_bank_arb dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .inst0   (inst0),
    .grant0  (grant0),
    .req1    (req1),
    .inst1   (inst1),
    .grant1  (grant1),
    .inst    (inst),
    .inst_en (inst_en),
    .error   (error),
    .count   (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model: expected output values after each rising edge.
  bit          m_valid = 1'b0;
  bit          m_fresh, m_err, m_last;
  bit          m_g0, m_g1, m_en;
  logic [11:0] m_inst;
  int          m_count;

  always @(posedge clock) begin : model
    bit          e0, e1;
    int          w;
    logic [11:0] cand;
    if (reset) begin
      m_valid = 1'b1; m_fresh = 1'b1; m_err = 1'b0; m_last = 1'b1;
      m_g0 = 1'b0; m_g1 = 1'b0; m_en = 1'b0; m_inst = 12'h000; m_count = 0;
    end else if (m_err || m_fresh) begin
      m_fresh = 1'b0;
      m_g0 = 1'b0; m_g1 = 1'b0; m_en = 1'b0; m_inst = 12'h000; m_count = 0;
    end else begin
      e0 = req0 && !m_g0;
      e1 = req1 && !m_g1;
      w  = -1;
      if (e0 && e1)  w = m_last ? 0 : 1;
      else if (e0)   w = 0;
      else if (e1)   w = 1;
      m_g0 = 1'b0; m_g1 = 1'b0; m_en = 1'b0;
      if (w >= 0) begin
        cand = (w == 0) ? inst0 : inst1;
        if (OPCHECK && (cand[11:8] > 4'h5)) begin
          m_err = 1'b1; m_inst = 12'h000; m_count = 0;
        end else begin
          m_inst  = cand;
          m_en    = 1'b1;
          m_g0    = (w == 0);
          m_g1    = (w == 1);
          m_count = (m_count + 1) % 256;
          m_last  = (w == 1);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("cmp_grant0",  grant0,  m_g0);
      chk("cmp_grant1",  grant1,  m_g1);
      chk("cmp_inst_en", inst_en, m_en);
      chk("cmp_inst",    inst,    m_inst);
      chk("cmp_error",   error,   m_err);
      chk("cmp_count",   count,   m_count[7:0]);
    end
  end

  // Apply one reset cycle with the given request inputs; returns at the release negedge.
  task automatic start(input logic r0, input logic [11:0] i0, input logic r1, input logic [11:0] i1);
    reset = 1'b1;
    req0 = r0; inst0 = i0; req1 = r1; inst1 = i1;
    @(negedge clock);
    chk("rst_outputs", {grant0, grant1, inst_en, error, inst, count}, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("por_count", count, 32'h00);
    chk("por_flags", {grant0, grant1, inst_en, error}, 32'h0);

    // Solo requester 0 with a held instruction.
    req0 = 1'b1; inst0 = 12'h2A5; reset = 1'b0;
    @(negedge clock); chk("solo_n1_grant0", grant0, 32'h0);
    @(negedge clock);
    chk("solo_n2_grant0", grant0, 32'h1);
    chk("solo_n2_inst", inst, 32'h2A5);
    chk("solo_n2_inst_en", inst_en, 32'h1);
    chk("solo_n2_count", count, 32'h01);
    @(negedge clock);
    chk("solo_n3_grant0", grant0, 32'h0);
    chk("solo_n3_inst_hold", inst, 32'h2A5);
    @(negedge clock);
    chk("solo_n4_grant0", grant0, 32'h1);
    chk("solo_n4_count", count, 32'h02);
    repeat (508) @(negedge clock);
    chk("wrap_256_count", count, 32'h00);
    repeat (2) @(negedge clock);
    chk("wrap_257_count", count, 32'h01);

    // Contention: alternating grants starting with requester 0.
    start(1'b1, 12'h311, 1'b1, 12'h422);
    @(negedge clock); chk("cont_n1_idle", inst_en, 32'h0);
    @(negedge clock); chk("cont_n2", {grant0, grant1, inst}, {18'h0, 2'b10, 12'h311});
    @(negedge clock); chk("cont_n3", {grant0, grant1, inst}, {18'h0, 2'b01, 12'h422});
    @(negedge clock); chk("cont_n4", {grant0, grant1, inst}, {18'h0, 2'b10, 12'h311});
    @(negedge clock); chk("cont_n5", {grant0, grant1, inst}, {18'h0, 2'b01, 12'h422});
    chk("cont_n5_count", count, 32'h04);

    // Reset mid-stream with both still requesting.
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_outputs", {grant0, grant1, inst_en, error, inst, count}, 32'h0);
    reset = 1'b0;
    @(negedge clock); chk("mid_n1_grants", {grant0, grant1}, 32'h0);
    @(negedge clock); chk("mid_n2_tie", {grant0, grant1}, 32'h2);
    @(negedge clock); chk("mid_n3_tie", {grant0, grant1}, 32'h1);

    // Request seen only during reset is discarded.
    start(1'b1, 12'h155, 1'b0, 12'h000);
    req0 = 1'b0;
    repeat (3) begin
      @(negedge clock); chk("discard_no_grant", {grant0, grant1, inst_en}, 32'h0);
    end

    // Opcode 9 from requester 1 alone.
    start(1'b0, 12'h000, 1'b1, 12'h9FF);
    repeat (2) @(negedge clock);
`ifdef REG_BANK_ARB_OPCHECK_EN
    chk("opchk_grant1", grant1, 32'h0);
    chk("opchk_inst_en", inst_en, 32'h0);
    chk("opchk_error", error, 32'h1);
    req0 = 1'b1; inst0 = 12'h100;
    repeat (3) @(negedge clock);
    chk("opchk_sticky", {error, grant0, inst_en}, 32'h4);
    reset = 1'b1;
    @(negedge clock);
    chk("opchk_rst", {error, count}, 32'h0);
    reset = 1'b0;
`else
    chk("noopchk_grant1", grant1, 32'h1);
    chk("noopchk_inst", inst, 32'h9FF);
    chk("noopchk_error", error, 32'h0);
    repeat (3) @(negedge clock);
    chk("noopchk_error_later", error, 32'h0);
`endif
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
